// File: rtl/uart_rx_core_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : uart_rx_core_if                                        |
// | Purpose  : Byte handshake between the UART receiver and consumer  |
// | Revision : 1.0                                                    |
// +------------------------------------------------------------------+
interface uart_rx_core_if;
    logic [7:0] rx_data;
    logic       rx_avail;
    logic       rx_error;
    logic       rx_ack;

    modport master (
        output rx_data,
        output rx_avail,
        output rx_error,
        input  rx_ack
    );

    modport slave (
        input  rx_data,
        input  rx_avail,
        input  rx_error,
        output rx_ack
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : uart_rx_core                                           |
// | Purpose  : 16x oversampling 8N1 receiver; even parity (8E1) when  |
// |            UART_RX_PARITY_EN is defined                           |
// | Revision : 1.0                                                    |
// +------------------------------------------------------------------+
module uart_rx_core #(
    parameter int FREQ_HZ = 100000000,
    parameter int BAUD    = 115200
) (
    input  wire logic      clk,
    input  wire logic      reset_n,
    input  wire logic      uart_rxd,
    uart_rx_core_if.master rx_if
);
    localparam int c_DIV   = FREQ_HZ / (BAUD * 16);
    localparam int c_DIV_W = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_MAX = c_DIV_W'(c_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY    = 3'd3,
`endif
        S_STOP      = 3'd4,
        S_WAIT_HIGH = 3'd5
    } state_t;

    state_t             r_state;
    logic [1:0]         r_sync;
    logic [c_DIV_W-1:0] r_div;
    logic [3:0]         r_cnt;
    logic [2:0]         r_bit;
    logic [7:0]         r_sr;
    logic               r_s7;
    logic               r_s8;
    logic               r_done;
    logic               r_ferr;
    logic [7:0]         r_rx_data;
    logic               r_rx_avail;
    logic               r_rx_error;

    logic               w_rxs;
    logic               w_tick;
    logic [3:0]         w_cnt_n;
    logic               w_s9;
    logic               w_s15;
    logic               w_vote;
    logic               w_perr;

    assign w_rxs   = r_sync[1];
    assign w_tick  = (r_div == c_DIV_MAX);
    assign w_cnt_n = r_cnt + 4'd1;
    assign w_s9    = w_tick && (w_cnt_n == 4'd9);
    assign w_s15   = w_tick && (w_cnt_n == 4'd15);
    assign w_vote  = (r_s7 & r_s8) | (r_s7 & w_rxs) | (r_s8 & w_rxs);

`ifdef UART_RX_PARITY_EN
    logic r_perr;
    assign w_perr = r_perr;
`else
    assign w_perr = 1'b0;
`endif

    assign rx_if.rx_data  = r_rx_data;
    assign rx_if.rx_avail = r_rx_avail;
    assign rx_if.rx_error = r_rx_error;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], uart_rxd};
        end
    end

    // Parked at zero while idle so a new frame always starts phase-aligned to its edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div <= '0;
        end else if (r_state == S_IDLE || r_state == S_WAIT_HIGH || w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_sr       <= '0;
            r_s7       <= 1'b1;
            r_s8       <= 1'b1;
            r_done     <= 1'b0;
            r_ferr     <= 1'b0;
            r_rx_data  <= '0;
            r_rx_avail <= 1'b0;
            r_rx_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_perr     <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            if (w_tick) begin
                r_cnt <= w_cnt_n;
                if (w_cnt_n == 4'd7) r_s7 <= w_rxs;
                if (w_cnt_n == 4'd8) r_s8 <= w_rxs;
            end

            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    r_bit <= '0;
`ifdef UART_RX_PARITY_EN
                    r_perr <= 1'b0;
`endif
                    if (!w_rxs) r_state <= S_START;
                end
                S_START: begin
                    if (w_s9 && w_vote) begin
                        r_state <= S_IDLE;
                    end else if (w_s15) begin
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_s9) r_sr <= {w_vote, r_sr[7:1]};
                    if (w_s15) begin
                        r_bit <= r_bit + 3'd1;
`ifdef UART_RX_PARITY_EN
                        if (r_bit == 3'd7) r_state <= S_PARITY;
`else
                        if (r_bit == 3'd7) r_state <= S_STOP;
`endif
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (w_s9)  r_perr  <= (w_vote != ^r_sr);
                    if (w_s15) r_state <= S_STOP;
                end
`endif
                S_STOP: begin
                    // Deciding on sample 9 re-arms early, absorbing baud mismatch
                    if (w_s9) begin
                        r_done  <= 1'b1;
                        r_ferr  <= ~w_vote;
                        r_state <= w_vote ? S_IDLE : S_WAIT_HIGH;
                    end
                end
                S_WAIT_HIGH: begin
                    if (w_rxs) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase

            // An ack arriving with the completion frees the slot, so it is not an overrun
            if (r_done) begin
                if (r_rx_avail && !rx_if.rx_ack) begin
                    r_rx_error <= 1'b1;
                end else begin
                    r_rx_data  <= r_sr;
                    r_rx_avail <= 1'b1;
                    r_rx_error <= r_ferr | w_perr;
                end
            end else if (rx_if.rx_ack && r_rx_avail) begin
                r_rx_avail <= 1'b0;
                r_rx_error <= 1'b0;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_uart_rx_core.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_uart_rx_core                                        |
// | Purpose  : Scoreboard bench for uart_rx_core at DIV=2             |
// | Revision : 1.0                                                    |
// +------------------------------------------------------------------+
module tb_uart_rx_core;
    localparam int FREQ_HZ  = 3200000;
    localparam int BAUD     = 100000;
    localparam int DIV      = FREQ_HZ / (BAUD * 16);
    localparam int BIT_CLKS = 16 * DIV;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_CLKS = BIT_CLKS;
`else
    localparam int PAR_CLKS = 0;
`endif
    // Start edge to rx_avail: sync + idle exit + 153 ticks + output register
    localparam int COMPLETE_CLKS = 2 + 1 + (9 * 16 + 9) * DIV + 1 + PAR_CLKS;
    // Window covers the nominal 307-clock figure and the stage budget, each +/-DIV
    localparam int LAT_LO = 307 + PAR_CLKS - DIV;
    localparam int LAT_HI = COMPLETE_CLKS + DIV;

    typedef struct packed {
        logic [7:0] data;
        logic       err;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    logic clk = 1'b0;
    logic reset_n;
    logic rxd;
    int   checks = 0;
    int   errors = 0;
    int   lat;
    bit   got;

    uart_rx_core_if rx_if();

    uart_rx_core #(
        .FREQ_HZ(FREQ_HZ),
        .BAUD   (BAUD)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .uart_rxd(rxd),
        .rx_if   (rx_if)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        idle(BIT_CLKS);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(par);
`endif
        send_bit(stop);
    endtask

    task automatic pulse_ack();
        rx_if.rx_ack = 1'b1;
        idle(1);
        rx_if.rx_ack = 1'b0;
    endtask

    task automatic wait_avail(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (rx_if.rx_avail === 1'b1) begin
                ok = 1'b1;
                break;
            end
            idle(1);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        rxd = 1'b1;
        rx_if.rx_ack = 1'b0;
        idle(3);
        checks++; if (rx_if.rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", rx_if.rx_data); end
        checks++; if (rx_if.rx_avail !== 1'b0) begin errors++; $display("FAIL reset_avail: got %b want 0", rx_if.rx_avail); end
        checks++; if (rx_if.rx_error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", rx_if.rx_error); end
        reset_n = 1'b1;
        idle(5);
    endtask

    task automatic test_clean();
        sb.push_back('{data: 8'hA5, err: 1'b0});
        fork
            send_frame(8'hA5, 1'b1, ^8'hA5);
            begin
                lat = 0;
                while (rx_if.rx_avail !== 1'b1 && lat < 1000) begin
                    idle(1);
                    lat++;
                end
            end
        join
        checks++; if (lat < LAT_LO || lat > LAT_HI) begin errors++; $display("FAIL clean_latency: got %0d want %0d..%0d", lat, LAT_LO, LAT_HI); end
        e = sb.pop_front();
        checks++; if (rx_if.rx_data !== e.data) begin errors++; $display("FAIL clean_data: got %h want %h", rx_if.rx_data, e.data); end
        checks++; if (rx_if.rx_error !== e.err) begin errors++; $display("FAIL clean_error: got %b want %b", rx_if.rx_error, e.err); end
        pulse_ack();
        checks++; if (rx_if.rx_avail !== 1'b0) begin errors++; $display("FAIL clean_ack_avail: got %b want 0", rx_if.rx_avail); end
        idle(10);
    endtask

    task automatic test_glitch();
        rxd = 1'b0;
        idle(10);
        rxd = 1'b1;
        idle(400);
        checks++; if (rx_if.rx_avail !== 1'b0) begin errors++; $display("FAIL glitch_avail: got %b want 0", rx_if.rx_avail); end
        sb.push_back('{data: 8'h3C, err: 1'b0});
        send_frame(8'h3C, 1'b1, ^8'h3C);
        wait_avail(1000, got);
        checks++; if (!got) begin errors++; $display("FAIL glitch_timeout: got no rx_avail want rx_avail=1"); end
        e = sb.pop_front();
        checks++; if (rx_if.rx_data !== e.data) begin errors++; $display("FAIL glitch_data: got %h want %h", rx_if.rx_data, e.data); end
        checks++; if (rx_if.rx_error !== e.err) begin errors++; $display("FAIL glitch_error: got %b want %b", rx_if.rx_error, e.err); end
        pulse_ack();
        idle(10);
    endtask

    task automatic test_framing();
        sb.push_back('{data: 8'h55, err: 1'b1});
        send_frame(8'h55, 1'b0, ^8'h55);
        idle(100);
        e = sb.pop_front();
        checks++; if (rx_if.rx_avail !== 1'b1) begin errors++; $display("FAIL frame_avail: got %b want 1", rx_if.rx_avail); end
        checks++; if (rx_if.rx_data !== e.data) begin errors++; $display("FAIL frame_data: got %h want %h", rx_if.rx_data, e.data); end
        checks++; if (rx_if.rx_error !== e.err) begin errors++; $display("FAIL frame_error: got %b want %b", rx_if.rx_error, e.err); end
        pulse_ack();
        checks++; if (rx_if.rx_error !== 1'b0) begin errors++; $display("FAIL frame_ack_error: got %b want 0", rx_if.rx_error); end
        idle(400);
        checks++; if (rx_if.rx_avail !== 1'b0) begin errors++; $display("FAIL frame_break_retrigger: got avail %b want 0", rx_if.rx_avail); end
        rxd = 1'b1;
        idle(40);
        sb.push_back('{data: 8'h81, err: 1'b0});
        send_frame(8'h81, 1'b1, ^8'h81);
        wait_avail(1000, got);
        checks++; if (!got) begin errors++; $display("FAIL frame_timeout: got no rx_avail want rx_avail=1"); end
        e = sb.pop_front();
        checks++; if (rx_if.rx_data !== e.data) begin errors++; $display("FAIL frame_next_data: got %h want %h", rx_if.rx_data, e.data); end
        checks++; if (rx_if.rx_error !== e.err) begin errors++; $display("FAIL frame_next_error: got %b want %b", rx_if.rx_error, e.err); end
        pulse_ack();
        idle(10);
    endtask

    task automatic test_overrun();
        sb.push_back('{data: 8'h11, err: 1'b1});
        send_frame(8'h11, 1'b1, ^8'h11);
        send_frame(8'h22, 1'b1, ^8'h22);
        idle(4);
        e = sb.pop_front();
        checks++; if (rx_if.rx_avail !== 1'b1) begin errors++; $display("FAIL ovr_avail: got %b want 1", rx_if.rx_avail); end
        checks++; if (rx_if.rx_data !== e.data) begin errors++; $display("FAIL ovr_data: got %h want %h", rx_if.rx_data, e.data); end
        checks++; if (rx_if.rx_error !== e.err) begin errors++; $display("FAIL ovr_error: got %b want %b", rx_if.rx_error, e.err); end
        pulse_ack();
        idle(10);
        sb.push_back('{data: 8'h22, err: 1'b0});
        send_frame(8'h11, 1'b1, ^8'h11);
        fork
            send_frame(8'h22, 1'b1, ^8'h22);
            begin
                idle(COMPLETE_CLKS - 1);
                pulse_ack();
            end
        join
        idle(2);
        e = sb.pop_front();
        checks++; if (rx_if.rx_avail !== 1'b1) begin errors++; $display("FAIL simack_avail: got %b want 1", rx_if.rx_avail); end
        checks++; if (rx_if.rx_data !== e.data) begin errors++; $display("FAIL simack_data: got %h want %h", rx_if.rx_data, e.data); end
        checks++; if (rx_if.rx_error !== e.err) begin errors++; $display("FAIL simack_error: got %b want %b", rx_if.rx_error, e.err); end
    endtask

    task automatic test_reset_midframe();
        // Parity argument keeps the line high after the reset in the 8E1 build
        fork
            send_frame(8'hF0, 1'b1, 1'b1);
            begin
                idle(5 * BIT_CLKS + 10);
                reset_n = 1'b0;
                #1;
                checks++; if (rx_if.rx_data !== 8'h00) begin errors++; $display("FAIL midrst_data: got %h want 00", rx_if.rx_data); end
                checks++; if (rx_if.rx_avail !== 1'b0) begin errors++; $display("FAIL midrst_avail: got %b want 0", rx_if.rx_avail); end
                checks++; if (rx_if.rx_error !== 1'b0) begin errors++; $display("FAIL midrst_error: got %b want 0", rx_if.rx_error); end
                idle(20);
                reset_n = 1'b1;
            end
        join
        idle(400);
        checks++; if (rx_if.rx_avail !== 1'b0) begin errors++; $display("FAIL midrst_no_frame: got avail %b want 0", rx_if.rx_avail); end
        sb.push_back('{data: 8'h0F, err: 1'b0});
        send_frame(8'h0F, 1'b1, ^8'h0F);
        wait_avail(1000, got);
        checks++; if (!got) begin errors++; $display("FAIL midrst_timeout: got no rx_avail want rx_avail=1"); end
        e = sb.pop_front();
        checks++; if (rx_if.rx_data !== e.data) begin errors++; $display("FAIL midrst_next_data: got %h want %h", rx_if.rx_data, e.data); end
        checks++; if (rx_if.rx_error !== e.err) begin errors++; $display("FAIL midrst_next_error: got %b want %b", rx_if.rx_error, e.err); end
        pulse_ack();
        idle(10);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        sb.push_back('{data: 8'h07, err: 1'b0});
        send_frame(8'h07, 1'b1, 1'b1);
        wait_avail(1000, got);
        e = sb.pop_front();
        checks++; if (rx_if.rx_data !== e.data) begin errors++; $display("FAIL par_ok_data: got %h want %h", rx_if.rx_data, e.data); end
        checks++; if (rx_if.rx_error !== e.err) begin errors++; $display("FAIL par_ok_error: got %b want %b", rx_if.rx_error, e.err); end
        pulse_ack();
        idle(10);
        sb.push_back('{data: 8'h07, err: 1'b1});
        send_frame(8'h07, 1'b1, 1'b0);
        wait_avail(1000, got);
        e = sb.pop_front();
        checks++; if (rx_if.rx_data !== e.data) begin errors++; $display("FAIL par_bad_data: got %h want %h", rx_if.rx_data, e.data); end
        checks++; if (rx_if.rx_error !== e.err) begin errors++; $display("FAIL par_bad_error: got %b want %b", rx_if.rx_error, e.err); end
        pulse_ack();
        idle(10);
    endtask
`endif

    initial begin
        test_reset();
        test_clean();
        test_glitch();
        test_framing();
        test_overrun();
        test_reset_midframe();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
